// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: 2-read/1-write register file with registered reads and a multi-cycle bulk clear.
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   we       write enable; waddr/wdata give the target entry and value
//   ren_a    read enable A; raddr_a selects the entry, rdata_a is the registered result
//   ren_b    read enable B; raddr_b selects the entry, rdata_b is the registered result
//   clr_req  starts a bulk clear when idle
//   busy     high while the bulk clear walks through the entries
module reg_file_2r1w #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 3,
    parameter bit ZERO_R0 = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              ren_a,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic              ren_b,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              clr_req,
    output logic              busy
);
    localparam int DEPTH = 2 ** ADDR_W;
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_ok;
    logic [DATA_W-1:0] nxt_a, nxt_b;
    assign busy  = (state == CLEAR);
    // Writes to entry 0 are discarded when it is hardwired to zero, so it never leaves 0.
    assign wr_ok = we && !busy && !(ZERO_R0 && waddr == '0);
    // Write-first bypass: an accepted write to the read address is forwarded.
    always_comb begin
        nxt_a = busy ? '0 : (wr_ok && waddr == raddr_a) ? wdata : (ZERO_R0 && raddr_a == '0) ? '0 : mem[raddr_a];
        nxt_b = busy ? '0 : (wr_ok && waddr == raddr_b) ? wdata : (ZERO_R0 && raddr_b == '0) ? '0 : mem[raddr_b];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            rdata_a <= '0;
            rdata_b <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (ren_a) rdata_a <= nxt_a;
            if (ren_b) rdata_b <= nxt_b;
            // wr_ok is low during CLEAR, so the clear and a write never target the array together.
            if (busy) mem[ptr] <= '0;
            else if (wr_ok) mem[waddr] <= wdata;
            case (state)
                IDLE: if (clr_req) begin
                    state <= CLEAR;
                    ptr   <= '0;
                end
                CLEAR: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == ADDR_W'(DEPTH - 1)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb_reg_file_2r1w: scoreboard bench for reg_file_2r1w with ZERO_R0=0 and ZERO_R0=1 instances.
module tb_reg_file_2r1w;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       we = 1'b0, ren_a = 1'b0, ren_b = 1'b0, clr_req = 1'b0;
    logic [2:0] waddr = '0, raddr_a = '0, raddr_b = '0;
    logic [7:0] wdata = '0;
    logic [7:0] rdata_a, rdata_b, z_rdata_a, z_rdata_b;
    logic       busy, z_busy;

    typedef struct {
        logic [7:0] a, b, za, zb;
        logic       busy;
    } exp_t;
    exp_t q[$];

    logic [7:0] m [8];
    logic [7:0] mz [8];
    logic [7:0] ra, rb, rza, rzb;
    bit         m_busy;
    int         m_ptr;
    int         n_err = 0, n_chk = 0;

    reg_file_2r1w #(.DATA_W(8), .ADDR_W(3), .ZERO_R0(1'b0)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .ren_a(ren_a), .raddr_a(raddr_a), .rdata_a(rdata_a),
        .ren_b(ren_b), .raddr_b(raddr_b), .rdata_b(rdata_b),
        .clr_req(clr_req), .busy(busy)
    );
    reg_file_2r1w #(.DATA_W(8), .ADDR_W(3), .ZERO_R0(1'b1)) dut_z (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .ren_a(ren_a), .raddr_a(raddr_a), .rdata_a(z_rdata_a),
        .ren_b(ren_b), .raddr_b(raddr_b), .rdata_b(z_rdata_b),
        .clr_req(clr_req), .busy(z_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m[i] = '0;
            mz[i] = '0;
        end
        ra = '0; rb = '0; rza = '0; rzb = '0;
        m_busy = 0;
        m_ptr = 0;
    endtask

    task automatic drive(input logic w, input logic [2:0] wa, input logic [7:0] wd,
                         input logic ea, input logic [2:0] aa, input logic eb, input logic [2:0] ab,
                         input logic c);
        we = w; waddr = wa; wdata = wd;
        ren_a = ea; raddr_a = aa; ren_b = eb; raddr_b = ab; clr_req = c;
    endtask

    task automatic step();
        exp_t e;
        bit wr, wrz;
        wr  = we && !m_busy;
        wrz = wr && waddr != 0;
        if (ren_a) begin
            ra  = m_busy ? 8'h00 : (wr && waddr == raddr_a) ? wdata : m[raddr_a];
            rza = (m_busy || raddr_a == 0) ? 8'h00 : (wrz && waddr == raddr_a) ? wdata : mz[raddr_a];
        end
        if (ren_b) begin
            rb  = m_busy ? 8'h00 : (wr && waddr == raddr_b) ? wdata : m[raddr_b];
            rzb = (m_busy || raddr_b == 0) ? 8'h00 : (wrz && waddr == raddr_b) ? wdata : mz[raddr_b];
        end
        if (m_busy) begin
            m[m_ptr] = '0;
            mz[m_ptr] = '0;
            if (m_ptr == 7) begin
                m_busy = 0;
                m_ptr = 0;
            end else m_ptr++;
        end else begin
            if (wr) m[waddr] = wdata;
            if (wrz) mz[waddr] = wdata;
            if (clr_req) begin
                m_busy = 1;
                m_ptr = 0;
            end
        end
        e = '{ra, rb, rza, rzb, m_busy};
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        check("rdata_a", rdata_a, e.a);
        check("rdata_b", rdata_b, e.b);
        check("z_rdata_a", z_rdata_a, e.za);
        check("z_rdata_b", z_rdata_b, e.zb);
        check("busy", busy, e.busy);
        check("z_busy", z_busy, e.busy);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_rdata_a", rdata_a, 0);
        check("rst_rdata_b", rdata_b, 0);
        check("rst_busy", busy, 0);
        check("rst_z_busy", z_busy, 0);
        check("rst_z_rdata_a", z_rdata_a, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2;
        do_reset();
        // single write then read on A only
        drive(1, 3'd3, 8'hA5, 0, 3'd0, 0, 3'd0, 0); step();
        drive(0, 3'd0, 8'h00, 1, 3'd3, 0, 3'd0, 0); step();
        check("req037_a", rdata_a, 8'hA5);
        check("req037_b", rdata_b, 8'h00);
        // write-first bypass on both ports
        drive(1, 3'd5, 8'h3C, 1, 3'd5, 1, 3'd5, 0); step();
        check("req038_a", rdata_a, 8'h3C);
        check("req038_b", rdata_b, 8'h3C);
        // read hold while the entry keeps changing
        drive(1, 3'd2, 8'h11, 0, 3'd0, 0, 3'd0, 0); step();
        drive(0, 3'd0, 8'h00, 1, 3'd2, 0, 3'd0, 0); step();
        for (int i = 0; i < 3; i++) begin
            drive(1, 3'd2, 8'h20 + 8'(i), 0, 3'd2, 0, 3'd0, 0); step();
        end
        check("req042_hold", rdata_a, 8'h11);
        // hardwired zero entry (dut_z) versus normal entry 0 (dut)
        drive(1, 3'd0, 8'hFF, 0, 3'd0, 0, 3'd0, 0); step();
        drive(1, 3'd1, 8'h77, 1, 3'd0, 1, 3'd1, 0); step();
        check("req040_z0", z_rdata_a, 8'h00);
        check("req040_z1", z_rdata_b, 8'h77);
        check("req040_n0", rdata_a, 8'hFF);
        drive(1, 3'd0, 8'hEE, 1, 3'd0, 0, 3'd0, 0); step();
        check("req040_z0_bypass", z_rdata_a, 8'h00);
        // fill, verify, then clear with a same-edge write
        for (int i = 0; i < 8; i++) begin
            drive(1, 3'(i), 8'(8'h11 * (i + 1)), 1, 3'(i), 1, 3'(7 - i), 0); step();
        end
        for (int i = 0; i < 8; i++) begin
            drive(0, 3'd0, 8'h00, 1, 3'(i), 1, 3'(i), 0); step();
        end
        drive(1, 3'd6, 8'h99, 1, 3'd4, 0, 3'd0, 1); step();
        check("req039_busy_rise", busy, 1);
        for (int i = 0; i < 8; i++) begin
            drive(1, 3'($urandom_range(0, 7)), 8'($urandom_range(1, 255)), 1, 3'($urandom_range(0, 7)),
                  1, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            step();
        end
        check("req039_busy_fall", busy, 0);
        for (int i = 0; i < 8; i++) begin
            drive(0, 3'd0, 8'h00, 1, 3'(i), 1, 3'(7 - i), 0); step();
            check("req039_zero", rdata_a, 8'h00);
        end
        // clr_req held high re-enters after one idle cycle
        for (int i = 0; i < 20; i++) begin
            drive(1, 3'(i), 8'h40 + 8'(i), 1, 3'(i), 0, 3'd0, 1); step();
        end
        drive(0, 3'd0, 8'h00, 0, 3'd0, 0, 3'd0, 0);
        while (m_busy) step();
        // asynchronous reset in the middle of a clear
        drive(1, 3'd7, 8'h5A, 0, 3'd0, 0, 3'd0, 0); step();
        drive(0, 3'd0, 8'h00, 1, 3'd7, 1, 3'd7, 0); step();
        check("req041_pre", rdata_a, 8'h5A);
        drive(0, 3'd0, 8'h00, 0, 3'd0, 0, 3'd0, 1); step();
        drive(0, 3'd0, 8'h00, 0, 3'd0, 0, 3'd0, 0); step(); step();
        check("req041_busy_mid", busy, 1);
        #2;
        do_reset();
        drive(0, 3'd0, 8'h00, 1, 3'd7, 1, 3'd7, 0); step();
        check("req041_post", rdata_a, 8'h00);
        drive(1, 3'd4, 8'hC3, 1, 3'd4, 0, 3'd0, 0); step();
        check("post_reset_write", rdata_a, 8'hC3);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/reg_file_2r1w.md
REG_FILE_2R1W -- requirements
Module: reg_file_2r1w

Interface
REQ-001 Parameter DATA_W, default 8: data width in bits.
REQ-002 Parameter ADDR_W, default 3: address width; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter ZERO_R0, default 0: 1 = entry 0 is hardwired to zero.
REQ-004 clk  input  1  single clock; all sequential logic updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 we  input  1  write enable.
REQ-007 waddr  input  ADDR_W  write address.
REQ-008 wdata  input  DATA_W  write data.
REQ-009 ren_a  input  1  read enable, port A.
REQ-010 raddr_a  input  ADDR_W  read address, port A.
REQ-011 rdata_a  output  DATA_W  registered read data, port A.
REQ-012 ren_b  input  1  read enable, port B.
REQ-013 raddr_b  input  ADDR_W  read address, port B.
REQ-014 rdata_b  output  DATA_W  registered read data, port B.
REQ-015 clr_req  input  1  request to bulk-clear all entries.
REQ-016 busy  output  1  high while a bulk clear is in progress.

Function
REQ-017 Storage: DEPTH words of DATA_W bits.
REQ-018 Write: at a rising edge with we=1 and busy=0, the entry at waddr takes wdata.
REQ-019 With we=1 and busy=1, the write is dropped and no entry changes.
REQ-020 With ZERO_R0=1, writes to address 0 are dropped and reads of address 0 return 0.
REQ-021 Read latency is 1 cycle: at a rising edge with ren_x=1 and busy=0, rdata_x takes the entry at raddr_x.
REQ-022 With ren_x=0, rdata_x holds its previous value.
REQ-023 Write-first bypass: a read and an accepted write to the same address at the same edge return wdata, subject to REQ-020.
REQ-024 Ports A and B are independent and may read the same address at the same edge.
REQ-025 With ren_x=1 and busy=1, rdata_x is loaded with 0.
REQ-026 FSM has two states, IDLE and CLEAR; busy=1 exactly when the state is CLEAR.
REQ-027 IDLE to CLEAR: at an edge with clr_req=1 in IDLE, clear pointer ptr is set to 0.
REQ-028 A write accepted at that same edge is performed, then overwritten by the clear.
REQ-029 In CLEAR, each edge sets entry ptr to 0 and increments ptr.
REQ-030 At the edge that clears entry DEPTH-1, the state returns to IDLE and ptr wraps to 0.
REQ-031 busy is high for exactly DEPTH cycles per clear.
REQ-032 clr_req is ignored while in CLEAR; there is no queuing.
REQ-033 clr_req held high continuously re-enters CLEAR on the edge after busy falls.

Reset
REQ-034 While rst=1, independent of clk: all entries are 0, rdata_a=0, rdata_b=0, state is IDLE, busy=0, ptr=0.
REQ-035 Reset asserted mid-clear aborts the clear immediately.
REQ-036 After rst deasserts, normal operation begins at the first rising edge.

Verification
REQ-037 Write 8'hA5 to addr 3, then read addr 3 on A with ren_a=1 -> rdata_a=8'hA5 one cycle after the read edge; rdata_b unchanged.
REQ-038 Same edge: we=1, waddr=5, wdata=8'h3C, ren_a=ren_b=1, raddr_a=raddr_b=5 -> both ports=8'h3C next cycle.
REQ-039 Fill all 8 entries with non-zero data, pulse clr_req -> busy high 8 cycles; writes and reads during busy are dropped/return 0; all entries read 0 afterward.
REQ-040 ZERO_R0=1: write 8'hFF to addr 0, read addr 0 -> 0; addr 1 behaves normally.
REQ-041 Assert rst asynchronously between edges mid-clear -> busy and rdata drop to 0 at once; after release, addr 7 (previously written) reads 0.
REQ-042 Hold ren_a=0 for 3 cycles after reading 8'h11 while writing other values to that address -> rdata_a stays 8'h11.
